// File: rtl/hermes_switch_control.sv
// -----------------------------------------------------------------------------
// hermes_switch_control
//
// Switch control for a 5-port Hermes NoC router. Arbitrates pending header
// flits round-robin, routes the winner with XY routing against the router
// ADDRESS, allocates the chosen output, and frees outputs once the owning
// input has finished sending its packet.
//
// Optional feature macro: HERMES_SC_FAST_ARB_EN
//   undefined : IDLE -> ARB -> ROUTE -> GRANT, 4-cycle request-to-ack latency
//   defined   : ARB and ROUTE merged into one state, 3-cycle latency
//
// Ports
//   clk_i      : single clock, rising edge
//   rst_i      : synchronous, active-high reset
//   req_i      : per input, a header flit is waiting to be routed
//   header_i   : per input, header flit; target X = [15:8], target Y = [7:0]
//   sending_i  : per input, the buffer is still forwarding its packet
//   ack_h_o    : per input, one-cycle grant pulse
//   free_o     : per output, port is unallocated
//   inport_o   : per output, input port connected to it
//   outport_o  : per input, output port allocated to it
// -----------------------------------------------------------------------------
package HermesPkg;
  localparam int NPORT = 5;

  typedef logic [2:0] hermes_port_t;

  localparam hermes_port_t EAST  = 3'd0;
  localparam hermes_port_t WEST  = 3'd1;
  localparam hermes_port_t NORTH = 3'd2;
  localparam hermes_port_t SOUTH = 3'd3;
  localparam hermes_port_t LOCAL = 3'd4;
endpackage

module hermes_switch_control
  import HermesPkg::*;
#(
  parameter int          FLIT_SIZE = 32,
  parameter logic [15:0] ADDRESS   = 16'h0000
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic         [NPORT-1:0]             req_i,
  input  logic         [NPORT-1:0][FLIT_SIZE-1:0] header_i,
  input  logic         [NPORT-1:0]             sending_i,
  output logic         [NPORT-1:0]             ack_h_o,
  output logic         [NPORT-1:0]             free_o,
  output hermes_port_t [NPORT-1:0]             inport_o,
  output hermes_port_t [NPORT-1:0]             outport_o
);

  localparam logic [7:0] LOCAL_X = ADDRESS[15:8];
  localparam logic [7:0] LOCAL_Y = ADDRESS[7:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
`ifndef HERMES_SC_FAST_ARB_EN
  localparam logic [1:0] S_ROUTE = 2'd2;
`endif
  localparam logic [1:0] S_GRANT = 2'd3;

  logic [1:0]       state;
  hermes_port_t     last;     // most recently served input (granted or blocked)
  hermes_port_t     sel;      // input being served in this pass
  hermes_port_t     dir;      // output requested by sel
  hermes_port_t     rr_sel;
  hermes_port_t     rr_cand;
  logic             rr_found;
  logic [NPORT-1:0] release_vec;

  // Only the 16 address bits of a header take part in routing; the payload
  // bits above are deliberately ignored.
  logic header_unused;
  assign header_unused = ^header_i;

  // XY routing: resolve X first, then Y, LOCAL when both match.
  function automatic hermes_port_t xy_route(input logic [15:0] target);
    if (target[15:8] > LOCAL_X) return EAST;
    if (target[15:8] < LOCAL_X) return WEST;
    if (target[7:0]  > LOCAL_Y) return NORTH;
    if (target[7:0]  < LOCAL_Y) return SOUTH;
    return LOCAL;
  endfunction

  // Round-robin pick: first requesting input starting just after last.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = LOCAL;
    rr_cand  = (last == LOCAL) ? EAST : last + 3'd1;
    for (int k = 0; k < NPORT; k++) begin
      if (!rr_found && req_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
      rr_cand = (rr_cand == LOCAL) ? EAST : rr_cand + 3'd1;
    end
  end

  // An allocated output is released once its connected input stops sending.
  // Release only touches outputs with free_o=0 and a grant only touches one
  // with free_o=1, so the two never collide on the same output.
  always_comb begin
    release_vec = '0;
    for (int o = 0; o < NPORT; o++) begin
      release_vec[o] = !free_o[o] && !sending_i[inport_o[o]];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sel and dir are reset too even though every path writes them
      // before use; it keeps the control path free of X after reset.
      state     <= S_IDLE;
      last      <= LOCAL;
      sel       <= LOCAL;
      dir       <= LOCAL;
      free_o    <= '1;
      ack_h_o   <= '0;
      inport_o  <= {NPORT{LOCAL}};
      outport_o <= {NPORT{LOCAL}};
    end else begin
      ack_h_o <= '0;
      free_o  <= free_o | release_vec;

      case (state)
        S_IDLE: begin
          // Waiting out an ack pulse gives the granted buffer time to drop req.
          if ((|req_i) && (ack_h_o == '0)) state <= S_ARB;
        end

        S_ARB: begin
          if (rr_found) begin
            sel <= rr_sel;
`ifdef HERMES_SC_FAST_ARB_EN
            dir   <= xy_route(header_i[rr_sel][15:0]);
            state <= S_GRANT;
`else
            state <= S_ROUTE;
`endif
          end else begin
            state <= S_IDLE;
          end
        end

`ifndef HERMES_SC_FAST_ARB_EN
        S_ROUTE: begin
          dir   <= xy_route(header_i[sel][15:0]);
          state <= S_GRANT;
        end
`endif

        S_GRANT: begin
          // last advances even when blocked so a stalled header cannot
          // starve the other inputs.
          last <= sel;
          if (free_o[dir]) begin
            free_o[dir]    <= 1'b0;
            inport_o[dir]  <= sel;
            outport_o[sel] <= dir;
            ack_h_o[sel]   <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hermes_switch_control.sv
// -----------------------------------------------------------------------------
// tb_hermes_switch_control
//
// Directed table of single-request routes, hand-written contention / blocking
// / reset sequences, and a randomized run against a transaction-level model.
// Router address 16'h0101 (X=1, Y=1).
// -----------------------------------------------------------------------------
module tb_hermes_switch_control;
  import HermesPkg::*;

  localparam int          FLIT_SIZE = 32;
  localparam logic [15:0] ADDR      = 16'h0101;
`ifdef HERMES_SC_FAST_ARB_EN
  localparam int          LAT       = 3;
`else
  localparam int          LAT       = 4;
`endif
  localparam logic [14:0] ALL_LOCAL = {3'd4, 3'd4, 3'd4, 3'd4, 3'd4};

  logic clk = 1'b0;
  logic rst;
  logic [NPORT-1:0]                req;
  logic [NPORT-1:0]                snd;
  logic [NPORT-1:0][FLIT_SIZE-1:0] hdr;
  logic [NPORT-1:0]                ack;
  logic [NPORT-1:0]                free;
  hermes_port_t [NPORT-1:0]        inport;
  hermes_port_t [NPORT-1:0]        outport;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hermes_switch_control #(.FLIT_SIZE(FLIT_SIZE), .ADDRESS(ADDR)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .header_i (hdr),
    .sending_i(snd),
    .ack_h_o  (ack),
    .free_o   (free),
    .inport_o (inport),
    .outport_o(outport)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: returns at the following falling edge, outputs settled.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    snd = '0;
    hdr = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_free"},    free,    32'h1f);
    check({tag, "_ack"},     ack,     32'h0);
    check({tag, "_inport"},  inport,  ALL_LOCAL);
    check({tag, "_outport"}, outport, ALL_LOCAL);
  endtask

  // Waits (bounded) for any ack pulse and checks it is the expected one.
  task automatic wait_ack(input hermes_port_t src, input int max_cyc, input string tag);
    int waited = 0;
    while (ack == '0 && waited < max_cyc) begin
      cyc();
      waited++;
    end
    check({tag, "_ack"}, ack, 32'(1) << src);
  endtask

  function automatic logic [FLIT_SIZE-1:0] mk_hdr(input logic [15:0] a);
    return {16'($urandom), a};
  endfunction

  // ---------------- transaction-level reference model ----------------------
  int               m_phase;   // 0 waiting, 1 choosing, 2 routing, 3 granting
  int               m_win;
  int               m_dir;
  int               m_last;
  logic [NPORT-1:0] m_free;
  logic [NPORT-1:0] m_ack;
  int               m_in  [NPORT];
  int               m_out [NPORT];

  function automatic int route_of(input logic [15:0] h);
    int tx = int'(h[15:8]);
    int ty = int'(h[7:0]);
    int lx = int'(ADDR[15:8]);
    int ly = int'(ADDR[7:0]);
    if (tx > lx) return 0;
    if (tx < lx) return 1;
    if (ty > ly) return 2;
    if (ty < ly) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_win   = 4;
    m_dir   = 4;
    m_last  = 4;
    m_free  = '1;
    m_ack   = '0;
    for (int i = 0; i < NPORT; i++) begin
      m_in[i]  = 4;
      m_out[i] = 4;
    end
  endtask

  task automatic model_step();
    logic [NPORT-1:0] ack_was  = m_ack;
    logic [NPORT-1:0] free_was = m_free;
    int pick = -1;
    m_ack = '0;
    for (int o = 0; o < NPORT; o++)
      if (!free_was[o] && !snd[m_in[o]]) m_free[o] = 1'b1;
    case (m_phase)
      0: if (req != '0 && ack_was == '0) m_phase = 1;
      1: begin
        for (int k = 1; k <= NPORT; k++)
          if (pick < 0 && req[(m_last + k) % NPORT]) pick = (m_last + k) % NPORT;
        if (pick < 0) m_phase = 0;
        else begin
          m_win = pick;
`ifdef HERMES_SC_FAST_ARB_EN
          m_dir   = route_of(hdr[pick][15:0]);
          m_phase = 3;
`else
          m_phase = 2;
`endif
        end
      end
      2: begin
        m_dir   = route_of(hdr[m_win][15:0]);
        m_phase = 3;
      end
      default: begin
        m_last = m_win;
        if (free_was[m_dir]) begin
          m_free[m_dir] = 1'b0;
          m_in[m_dir]   = m_win;
          m_out[m_win]  = m_dir;
          m_ack[m_win]  = 1'b1;
        end
        m_phase = 0;
      end
    endcase
  endtask

  // ---------------- directed route table ------------------------------------
  typedef struct {
    hermes_port_t src;
    logic [15:0]  header;
    hermes_port_t dir;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{LOCAL, 16'h0301, EAST};
    vecs[1] = '{SOUTH, 16'h0100, SOUTH};   // U-turn
    vecs[2] = '{NORTH, 16'h0102, NORTH};   // U-turn
    vecs[3] = '{EAST,  16'h0101, LOCAL};
    vecs[4] = '{WEST,  16'h0001, WEST};
    vecs[5] = '{WEST,  16'h0201, EAST};

    rst = 1'b1; req = '0; snd = '0; hdr = '0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      check_reset_state("tbl_reset");
      hdr[vecs[v].src] = mk_hdr(vecs[v].header);
      req[vecs[v].src] = 1'b1;
      snd[vecs[v].src] = 1'b1;
      for (int c = 1; c <= LAT; c++) begin
        cyc();
        if (c < LAT) check("tbl_early_ack", ack, 32'h0);
      end
      check("tbl_ack",     ack, 32'(1) << vecs[v].src);
      check("tbl_outport", outport[vecs[v].src], vecs[v].dir);
      check("tbl_inport",  inport[vecs[v].dir],  vecs[v].src);
      check("tbl_free",    free, 32'h1f & ~(32'(1) << vecs[v].dir));
      req = '0;
      cyc();
      check("tbl_ack_pulse", ack, 32'h0);
      check("tbl_free_busy", free, 32'h1f & ~(32'(1) << vecs[v].dir));
      snd = '0;
      cyc();
      check("tbl_release", free, 32'h1f);
      check("tbl_hold_inport",  inport[vecs[v].dir],  vecs[v].src);
      check("tbl_hold_outport", outport[vecs[v].src], vecs[v].dir);
    end

    // -------- contention: WEST and NORTH both want WEST ----------------------
    do_reset();
    hdr[WEST]  = mk_hdr(16'h0001);
    hdr[NORTH] = mk_hdr(16'h0001);
    req[WEST]  = 1'b1; req[NORTH] = 1'b1;
    snd[WEST]  = 1'b1; snd[NORTH] = 1'b1;
    wait_ack(WEST, LAT + 1, "cont_first");
    check("cont_out_west", outport[WEST], WEST);
    check("cont_in_west",  inport[WEST],  WEST);
    req[WEST] = 1'b0;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
        cyc();
        if (ack != '0) seen = 1'b1;
      end
      check("cont_blocked_no_ack", 32'(seen), 32'h0);
    end
    snd[WEST] = 1'b0;
    cyc();
    check("cont_release", free, 32'h1f);
    wait_ack(NORTH, 2 * (LAT + 1) + 2, "cont_second");
    check("cont_out_north", outport[NORTH], WEST);
    check("cont_in_north",  inport[WEST],  NORTH);
    req = '0;

    // -------- blocked header while EAST is busy ------------------------------
    do_reset();
    hdr[LOCAL] = mk_hdr(16'h0301);
    req[LOCAL] = 1'b1; snd[LOCAL] = 1'b1;
    wait_ack(LOCAL, LAT + 1, "blk_alloc");
    req[LOCAL] = 1'b0;
    hdr[SOUTH] = mk_hdr(16'h0201);
    req[SOUTH] = 1'b1; snd[SOUTH] = 1'b1;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        cyc();
        if (ack != '0) seen = 1'b1;
      end
      check("blk_no_ack", 32'(seen), 32'h0);
    end
    snd[LOCAL] = 1'b0;
    wait_ack(SOUTH, 2 * (LAT + 1) + 3, "blk_after_release");
    check("blk_out_south", outport[SOUTH], EAST);
    req = '0; snd = '0;

    // -------- reset in the routing step --------------------------------------
    do_reset();
    hdr[LOCAL] = mk_hdr(16'h0301);
    req[LOCAL] = 1'b1; snd[LOCAL] = 1'b1;
    wait_ack(LOCAL, LAT + 1, "rst_alloc");
    req[LOCAL] = 1'b0;
    cyc();
    hdr[WEST] = mk_hdr(16'h0001);
    req[WEST] = 1'b1; snd[WEST] = 1'b1;
    for (int c = 0; c < LAT - 2; c++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("rst_mid");
    req = '0;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
        cyc();
        if (ack != '0) seen = 1'b1;
      end
      check("rst_mid_no_ack", 32'(seen), 32'h0);
    end
    snd = '0;

    // -------- randomized run against the model -------------------------------
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [14:0] exp_in, exp_out;
      for (int i = 0; i < NPORT; i++) begin
        exp_in[i*3 +: 3]  = 3'(m_in[i]);
        exp_out[i*3 +: 3] = 3'(m_out[i]);
      end
      check("rand_ack",     ack,     m_ack);
      check("rand_free",    free,    m_free);
      check("rand_inport",  inport,  exp_in);
      check("rand_outport", outport, exp_out);
      for (int p = 0; p < NPORT; p++) begin
        req[p] = ($urandom_range(0, 3) == 0);
        snd[p] = ($urandom_range(0, 4) != 0);
        hdr[p] = {16'($urandom), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))};
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
